// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } adder_state_t;

  function automatic int unsigned chunk_count(input int unsigned w, input int unsigned n);
    return w / n;
  endfunction

  // Index register is at least one bit wide so K == 1 still has a legal counter.
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple-carry adder slice, reused every cycle by adder_seq_n.
module adder_slice #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_seq_n.sv
// Chunk-serial W-bit adder: N bits per clock through one adder_slice, valid/ready both sides.
// Define ADDER_SUB_EN to add a 'sub' input that turns the operation into a - b.
module adder_seq_n
  import adder_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         cout
);

  localparam int unsigned K  = chunk_count(W, N);
  localparam int unsigned IW = idx_width(K);
  localparam logic [IW-1:0] LastIdx = IW'(K - 1);

  if ((N == 0) || ((W % N) != 0)) begin : g_bad_width
    $error("adder_seq_n: W (%0d) must be a non-zero multiple of N (%0d)", W, N);
  end

  adder_state_t  state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [W-1:0]  y_q;
  logic          cout_q;

  logic [W-1:0]  b_in;
  logic          cin_in;
  logic [N-1:0]  slice_a;
  logic [N-1:0]  slice_b;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;

`ifdef ADDER_SUB_EN
  // Two's-complement subtract: invert b once at latch time and force the carry-in.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  adder_slice #(
    .N(N)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          y_q[idx_q*N +: N] <= slice_sum;
          carry_q           <= slice_cout;
          idx_q             <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_q  <= slice_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign cout      = cout_q;

  // A presented result must not move until the consumer takes it.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(y) && $stable(cout))
  );

endmodule

// File: tb/tb_adder_seq_n.sv
// Scoreboard bench for adder_seq_n: driver queues expected sums, monitor checks on handshake.
module tb_adder_seq_n;

  localparam int unsigned W = 16;
  localparam int unsigned N = 8;
  localparam int unsigned K = W / N;

  typedef struct {
    logic [W-1:0] y;
    logic         co;
    int           rise;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] y;
  logic         cout;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   rand_ready = 1'b0;
  bit   prev_v = 1'b0;
  exp_t sb[$];

  adder_seq_n #(
    .W(W),
    .N(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: full-width arithmetic, subtract as a + ~b + 1.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic sv);
    int           t = 0;
    exp_t         e;
    logic [W:0]   r;
    logic [W-1:0] bm;
    logic [W:0]   ci;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      check("send_wait_ready", in_ready, 1);
      return;
    end
    bm = sv ? ~bv : bv;
    ci = sv ? (W+1)'(1) : (W+1)'(cv);
    r  = {1'b0, av} + {1'b0, bm} + ci;
    e.y    = r[W-1:0];
    e.co   = r[W];
    e.rise = cyc + 1 + K;
    a = av;
    b = bv;
    cin = cv;
`ifdef ADDER_SUB_EN
    sub = sv;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wait_valid", out_valid, 1);
  endtask

  // Monitor: latency on rising out_valid, value on each handshake.
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) check("unexpected_result", out_valid, 0);
          else check("latency", cyc, sb[0].rise);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          me = sb.pop_front();
          check("sum_y", y, me.y);
          check("sum_cout", cout, me.co);
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic sv;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_y", y, 0);
    check("reset_cout", cout, 0);
    reset = 1'b0;

    // Carry ripples through both chunks into cout.
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();

    // Consumer stalls; result must hold.
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 1'b1, 1'b0);
    wait_valid();
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_y", y, 16'h1334);
      check("stall_cout", cout, 0);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_valid_drop", out_valid, 0);
    check("stall_in_ready", in_ready, 1);

    // Reset while running aborts the operation.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_y", y, 0);
    check("abort_cout", cout, 0);
    check("abort_in_ready", in_ready, 1);
    reset = 1'b0;

    // New operands offered during RUN and DONE are ignored.
    out_ready = 1'b0;
    send(16'h0102, 16'h0304, 1'b0, 1'b0);
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    a = 16'hAAAA;
    b = 16'h5555;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ignore_valid", out_valid, 1);
    check("ignore_y", y, 16'h0406);
    out_ready = 1'b1;
    drain();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("ignore_no_extra", out_valid, 0);

`ifdef ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    drain();
`endif

    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h00FF, 16'h0001, 1'b1, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
`ifdef ADDER_SUB_EN
      sv = 1'($urandom_range(0, 1));
`else
      sv = 1'b0;
`endif
      send(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)), sv);
    end
    drain();
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
